reg_bus_writer: RTL and testbench

//   Bus master for the signal_generator register port. Queues register write

---
 rtl/reg_bus_writer.sv | 130 +++++++++++++
 tb/tb_reg_bus_writer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_writer.sv
// Command FIFO plus strobe sequencer that replays queued {addr,data} writes as
// single-cycle register strobes, with a programmable low gap between them.
`timescale 1ns/1ps
module reg_bus_writer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DATA_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_data,
  input  logic                   flush,
  output logic                   write_strobe,
  output logic [ADDR_W-1:0]      address,
  output logic [DATA_W-1:0]      data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   idle
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned EntW = ADDR_W + DATA_W;

  typedef enum logic [1:0] {StIdle, StStrobe, StGap} state_e;

  state_e            state_q, state_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              strobe_q, strobe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [EntW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q;

  logic              full, empty, push, pop, try_issue;
  logic [EntW-1:0]   head;

  assign full      = (level_q == LvlW'(DEPTH));
  assign empty     = (level_q == '0);
  assign cmd_ready = !full;
  // No pass-through: a full FIFO refuses even when a pop happens this cycle.
  assign push      = cmd_valid && !full && !flush;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    strobe_d  = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    pop       = 1'b0;
    try_issue = 1'b0;
    unique case (state_q)
      StIdle:   try_issue = 1'b1;
      StStrobe: begin
        if (GAP_CYCLES > 0) begin
          gap_d   = GapW'(GAP_CYCLES);
          state_d = StGap;
        end else begin
          try_issue = 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapW'(1)) begin
          try_issue = 1'b1;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (try_issue) begin
      // A flush empties the queue on this edge, so nothing may be issued from it.
      if (!empty && !flush) begin
        pop              = 1'b1;
        strobe_d         = 1'b1;
        {addr_d, data_d} = head;
        state_d          = StStrobe;
      end else begin
        state_d = StIdle;
        gap_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      gap_q    <= '0;
      strobe_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      strobe_q <= strobe_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        level_q <= level_q + LvlW'(push) - LvlW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_addr, cmd_data};
  end

  assign write_strobe = strobe_q;
  assign address      = addr_q;
  assign data         = data_q;
  assign fifo_level   = level_q;
  assign idle         = empty && (state_q == StIdle);

endmodule

// File: tb/tb_reg_bus_writer.sv
// Directed bench for reg_bus_writer: accepted commands go to a scoreboard queue,
// and every observed strobe pops and checks the oldest expected {addr,data}.
`timescale 1ns/1ps
module tb_reg_bus_writer;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, flush;
  logic [2:0] cmd_addr;
  logic [4:0] cmd_data;
  logic       cmd_ready, write_strobe, idle;
  logic [2:0] address;
  logic [4:0] data;
  logic [2:0] fifo_level;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  logic [7:0]  exp_q[$];
  int unsigned strobe_cyc[$];
  logic        prev_strobe = 1'b0;

  reg_bus_writer #(
    .DEPTH(4),
    .GAP_CYCLES(2),
    .ADDR_W(3),
    .DATA_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .flush(flush),
    .write_strobe(write_strobe),
    .address(address),
    .data(data),
    .fifo_level(fifo_level),
    .idle(idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command (valid left high) and returns just after the edge that takes it.
  task automatic push_cmd(input logic [2:0] a, input logic [4:0] d);
    int w = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    while (!cmd_ready && w < 50) begin
      tick();
      w++;
    end
    check("push_ready", cmd_ready, 1'b1);
    exp_q.push_back({a, d});
    tick();
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!idle && w < 100) begin
      tick();
      w++;
    end
    check("wait_idle", idle, 1'b1);
  endtask

  always @(negedge clk) begin
    if (write_strobe) begin
      check("strobe_one_cycle", prev_strobe, 1'b0);
      check("strobe_expected", 32'(exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) check("strobe_addr_data", {address, data}, exp_q.pop_front());
      strobe_cyc.push_back(cyc);
    end
    prev_strobe <= write_strobe;
  end

  initial begin
    int n_push;
    int w;
    rst = 1'b1; cmd_valid = 1'b0; flush = 1'b0; cmd_addr = '0; cmd_data = '0;

    // T1 reset
    tick(); tick();
    check("t1_strobe", write_strobe, 1'b0);
    check("t1_address", address, 3'd0);
    check("t1_data", data, 5'd0);
    check("t1_level", fifo_level, 3'd0);
    check("t1_ready", cmd_ready, 1'b1);
    check("t1_idle", idle, 1'b1);
    rst = 1'b0;

    // T2 single write
    push_cmd(3'b010, 5'd9);
    cmd_valid = 1'b0;
    check("t2_no_strobe_at_push", write_strobe, 1'b0);
    tick();
    check("t2_strobe", write_strobe, 1'b1);
    check("t2_address", address, 3'd2);
    check("t2_data", data, 5'd9);
    tick();
    check("t2_strobe_low", write_strobe, 1'b0);
    check("t2_hold_address", address, 3'd2);
    check("t2_busy", idle, 1'b0);
    tick();
    check("t2_still_busy", idle, 1'b0);
    tick();
    check("t2_idle_again", idle, 1'b1);

    // T3 back-to-back
    strobe_cyc.delete();
    push_cmd(3'd0, 5'd5);
    push_cmd(3'd1, 5'd6);
    push_cmd(3'd4, 5'd7);
    cmd_valid = 1'b0;
    repeat (12) tick();
    check("t3_strobe_count", strobe_cyc.size(), 3);
    if (strobe_cyc.size() == 3) begin
      check("t3_spacing_1", strobe_cyc[1] - strobe_cyc[0], 3);
      check("t3_spacing_2", strobe_cyc[2] - strobe_cyc[1], 3);
    end

    // T4 full
    wait_idle();
    n_push = 0;
    do begin
      push_cmd(3'(n_push), 5'(n_push + 10));
      n_push++;
    end while (cmd_ready && n_push < 10);
    check("t4_level_full", fifo_level, 3'd4);
    check("t4_not_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b1; cmd_addr = 3'd7; cmd_data = 5'd31;
    w = 0;
    while (!cmd_ready && w < 20) begin
      tick();
      w++;
    end
    check("t4_ready_again", cmd_ready, 1'b1);
    check("t4_level_after_pop", fifo_level, 3'd3);
    check("t4_pop_strobe", write_strobe, 1'b1);
    exp_q.push_back({3'd7, 5'd31});
    tick();
    cmd_valid = 1'b0;
    check("t4_level_refilled", fifo_level, 3'd4);
    wait_idle();
    check("t4_all_drained", exp_q.size(), 0);

    // T5 flush during first strobe, with a simultaneous push that must be dropped
    strobe_cyc.delete();
    push_cmd(3'd1, 5'd1);
    push_cmd(3'd2, 5'd2);
    check("t5_first_strobe", write_strobe, 1'b1);
    cmd_addr = 3'd3; cmd_data = 5'd3; cmd_valid = 1'b1; flush = 1'b1;
    tick();
    exp_q.delete();
    flush = 1'b0; cmd_valid = 1'b0;
    check("t5_level_zero", fifo_level, 3'd0);
    check("t5_strobe_done", write_strobe, 1'b0);
    repeat (10) tick();
    check("t5_single_strobe", strobe_cyc.size(), 1);
    check("t5_idle", idle, 1'b1);

    // T6 reset mid-gap with two commands queued
    push_cmd(3'd1, 5'd11);
    push_cmd(3'd2, 5'd12);
    push_cmd(3'd3, 5'd13);
    cmd_valid = 1'b0;
    check("t6_level_before", fifo_level, 3'd2);
    check("t6_in_gap", write_strobe, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("t6_strobe", write_strobe, 1'b0);
    check("t6_level", fifo_level, 3'd0);
    check("t6_idle", idle, 1'b1);
    check("t6_address", address, 3'd0);
    push_cmd(3'd5, 5'd17);
    cmd_valid = 1'b0;
    check("t6_no_strobe_at_push", write_strobe, 1'b0);
    tick();
    check("t6_strobe_latency", write_strobe, 1'b1);
    check("t6_address_new", address, 3'd5);
    check("t6_data_new", data, 5'd17);
    tick();
    check("t6_strobe_low", write_strobe, 1'b0);

    wait_idle();
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
